instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM for the ev21g1 core.
//  - Fetches 32-bit instructions from program memory at the PC and latches them into the instruction register (IR).
//  - The IR drives instruction_decoder combinationally. The resulting 30-bit microinstruction is registered and held for the
//    execute datapath until it signals completion.
//  - Owns the PC, branch redirection, halt/resume, fetch-timeout fault and the retired-instruction counter.
// PARAMETERS
//  PC_WIDTH      10   program counter / program memory address width
//  INSTR_WIDTH   32   instruction width (IR, decoder input)
//  UINSTR_WIDTH  30   microinstruction width (decoder output)
//  TIMEOUT       16   max FETCH cycles without pm_ready before FAULT (>=2)
//  CNT_WIDTH     16   retired-instruction counter width
// PORTS
//  clk                  in   1             single clock, rising edge
//  reset                in   1             synchronous, active-high
//  pm_req               out  1             program memory read request
//  pm_addr              out  PC_WIDTH      read address (= pc)
//  pm_ready             in   1             pm_data valid this cycle
//  pm_data              in   INSTR_WIDTH   fetched instruction
//  dec_instruction      out  INSTR_WIDTH   IR to instruction_decoder
//  dec_microinstruction in   UINSTR_WIDTH  decoder output
//  exec_uinstr          out  UINSTR_WIDTH  registered microinstruction
//  exec_valid           out  1             exec_uinstr valid (EXECUTE)
//  exec_done            in   1             execute datapath finished
//  branch_taken         in   1             sampled with exec_done
//  branch_target        in   PC_WIDTH      next PC if branch_taken
//  halt_req             in   1             sampled with exec_done
//  resume               in   1             leave HALT
//  pc                   out  PC_WIDTH      current PC
//  halted               out  1             state==HALT
//  fault                out  1             state==FAULT
//  retired_count        out  CNT_WIDTH     completed instructions
// BEHAVIOUR
//  Reset (synchronous): state=FETCH; pc=0; IR=0; exec_uinstr=0; wait_cnt=0; retired_count=0.
//   All 1-bit outputs are 0. Reset mid-operation aborts any fetch/execute. pm_req is not asserted in the reset cycle.
//  States: FETCH, DECODE, EXECUTE, HALT, FAULT (registered; outputs are decoded from state/regs only).
//  FETCH:
//   - pm_req=1, pm_addr=pc.
//   - pm_ready=1: IR<=pm_data, wait_cnt<=0, ->DECODE.
//   - Otherwise wait_cnt++. If wait_cnt==TIMEOUT-1 (no ready), ->FAULT.
//  DECODE: pm_req=0; exec_uinstr<=dec_microinstruction; ->EXECUTE (exactly 1 cycle).
//  EXECUTE:
//   - exec_valid=1; exec_uinstr and IR are held stable.
//   - On exec_done: retired_count++ (wraps at 2^CNT_WIDTH).
//   - pc<=branch_taken ? branch_target : pc+1 (wraps modulo 2^PC_WIDTH).
//   - Next state: ->HALT if halt_req, else ->FETCH. The PC update happens even when halting.
//  HALT: halted=1; resume=1 -> FETCH at the updated pc. resume is ignored in all other states.
//  FAULT: fault=1; pc holds the failing address. Sticky: exited only by reset.
//  Latency: minimum 3 cycles per instruction (FETCH with ready, DECODE, EXECUTE with immediate done).
//  Ignored inputs:
//   - exec_done, branch_*, halt_req outside EXECUTE.
//   - pm_ready/pm_data outside FETCH.
//  Simultaneous events:
//   - branch_taken + halt_req: branch is applied, then halt.
//   - pm_ready on the TIMEOUT-th cycle: ready wins, no fault.
//  dec_instruction = IR at all times (combinational decoder sits between).
// TESTING
//  1. Reset, then pm_ready=1 at once with pm_data=32'h70002040, exec_done 1 cycle after exec_valid
//     -> pm_addr=0, IR=32'h70002040, exec_valid in cycle 3, pc=1, retired_count=1.
//  2. pm_ready delayed 5 cycles -> pm_req held high, pm_addr stable for 6 cycles, no fault. Then pm_ready never
//     (TIMEOUT=16) -> fault=1 after 16 FETCH cycles; pc unchanged; only reset clears it.
//  3. exec_done with branch_taken=1, branch_target=10'h3F0 -> next pm_addr=10'h3F0. At pc=10'h3FF, no branch -> pc wraps to 0.
//  4. exec_done with halt_req=1 at pc=4 -> halted=1, pc=5, pm_req=0. 10 idle cycles; resume -> FETCH at pm_addr=5.
//  5. Reset asserted in EXECUTE with exec_uinstr nonzero -> next cycle all reset values; exec_done pulses in FETCH/DECODE
//     -> no pc or count change.
//  6. 2^CNT_WIDTH+2 retired instructions (CNT_WIDTH=4 build) -> retired_count wraps to 2; the decoder output registered
//     in DECODE matches the decoder model for each IR value.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute control FSM for the ev21g1 core.
// Owns PC, IR, the registered microinstruction, halt/fault and retire count.
module instruction_sequencer #(
  parameter int PC_WIDTH     = 10,
  parameter int INSTR_WIDTH  = 32,
  parameter int UINSTR_WIDTH = 30,
  parameter int TIMEOUT      = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    pm_req,
  output logic [PC_WIDTH-1:0]     pm_addr,
  input  logic                    pm_ready,
  input  logic [INSTR_WIDTH-1:0]  pm_data,
  output logic [INSTR_WIDTH-1:0]  dec_instruction,
  input  logic [UINSTR_WIDTH-1:0] dec_microinstruction,
  output logic [UINSTR_WIDTH-1:0] exec_uinstr,
  output logic                    exec_valid,
  input  logic                    exec_done,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    halted,
  output logic                    fault,
  output logic [CNT_WIDTH-1:0]    retired_count
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic [UINSTR_WIDTH-1:0] uinstr_q, uinstr_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    uinstr_d = uinstr_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_FETCH: begin
        // ready on the last allowed cycle still wins over the timeout
        if (pm_ready) begin
          ir_d    = pm_data;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        uinstr_d = dec_microinstruction;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          cnt_d   = cnt_q + 1'b1;
          pc_d    = branch_taken ? branch_target : pc_q + 1'b1;
          state_d = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      uinstr_q <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      uinstr_q <= uinstr_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
    end
  end

  // the reset cycle itself must not issue a fetch
  assign pm_req          = (state_q == S_FETCH) && !reset;
  assign pm_addr         = pc_q;
  assign pc              = pc_q;
  assign dec_instruction = ir_q;
  assign exec_uinstr     = uinstr_q;
  assign exec_valid      = (state_q == S_EXEC);
  assign halted          = (state_q == S_HALT);
  assign fault           = (state_q == S_FAULT);
  assign retired_count   = cnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer.
// Driver pushes expected fetches; monitor checks each EXECUTE entry.
module tb_instruction_sequencer;

  localparam int PW = 10;
  localparam int IW = 32;
  localparam int UW = 30;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pm_req;
  logic [PW-1:0] pm_addr;
  logic          pm_ready;
  logic [IW-1:0] pm_data;
  logic [IW-1:0] dec_instruction;
  logic [UW-1:0] dec_microinstruction;
  logic [UW-1:0] exec_uinstr;
  logic          exec_valid;
  logic          exec_done;
  logic          branch_taken;
  logic [PW-1:0] branch_target;
  logic          halt_req;
  logic          resume;
  logic [PW-1:0] pc;
  logic          halted;
  logic          fault;
  logic [CW-1:0] retired_count;

  instruction_sequencer #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .UINSTR_WIDTH(UW),
    .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .pm_req(pm_req), .pm_addr(pm_addr),
    .pm_ready(pm_ready), .pm_data(pm_data),
    .dec_instruction(dec_instruction),
    .dec_microinstruction(dec_microinstruction),
    .exec_uinstr(exec_uinstr), .exec_valid(exec_valid),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req),
    .resume(resume), .pc(pc), .halted(halted),
    .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [UW-1:0] ucode(input logic [IW-1:0] d);
    return (d[31:2] ^ {d[1:0], d[31:4]}) + 30'h1234567;
  endfunction

  assign dec_microinstruction = ucode(dec_instruction);

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] ir;
    logic [UW-1:0] u;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [PW-1:0] mpc;
  logic [CW-1:0] mcnt;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // monitor: compare each new EXECUTE against the scoreboard
  initial begin
    exp_t cur;
    bit   prev;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (exec_valid && !prev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("ex_pc", pc, cur.pc);
          chk("ex_ir", dec_instruction, cur.ir);
          chk("ex_uinstr", exec_uinstr, cur.u);
        end
      end else if (exec_valid) begin
        chk("hold_ir", dec_instruction, cur.ir);
        chk("hold_uinstr", exec_uinstr, cur.u);
      end
      prev = exec_valid;
    end
  end

  task automatic chk_reset();
    chk("rst_req", pm_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_valid", exec_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt", retired_count, 0);
    chk("rst_ir", dec_instruction, 0);
    chk("rst_uinstr", exec_uinstr, 0);
    mpc  = '0;
    mcnt = '0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_ins();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    halt_req     = 1'b0;
    resume       = 1'b0;
  endtask

  task automatic do_fetch(input int dly, input logic [IW-1:0] d);
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", pm_req, 1);
      chk("wait_addr", pm_addr, mpc);
      chk("wait_fault", fault, 0);
      pm_ready      = 1'b0;
      pm_data       = $urandom;
      exec_done     = 1'($urandom);
      branch_taken  = 1'b1;
      branch_target = PW'($urandom);
      halt_req      = 1'($urandom);
      @(negedge clk);
    end
    clear_ins();
    chk("fetch_req", pm_req, 1);
    chk("fetch_addr", pm_addr, mpc);
    chk("fetch_valid", exec_valid, 0);
    pm_ready = 1'b1;
    pm_data  = d;
    sb.push_back('{pc: mpc, ir: d, u: ucode(d)});
    @(negedge clk);
    pm_ready      = 1'b0;
    pm_data       = $urandom;
    chk("dec_req", pm_req, 0);
    chk("dec_valid", exec_valid, 0);
    exec_done     = 1'b1;
    branch_taken  = 1'b1;
    branch_target = PW'($urandom);
    halt_req      = 1'($urandom);
    @(negedge clk);
    clear_ins();
  endtask

  task automatic do_exec(input int w, input bit br,
                         input logic [PW-1:0] tgt, input bit h);
    for (int i = 0; i < w; i++) begin
      chk("ex_wait_valid", exec_valid, 1);
      pm_ready = 1'b1;
      @(negedge clk);
    end
    pm_ready = 1'b0;
    chk("ex_valid", exec_valid, 1);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt_req      = h;
    @(negedge clk);
    clear_ins();
    branch_target = PW'($urandom);
    mpc  = br ? tgt : PW'(mpc + 1);
    mcnt = CW'(mcnt + 1);
    chk("ret_pc", pc, mpc);
    chk("ret_cnt", retired_count, mcnt);
    chk("ret_halted", halted, h);
    chk("ret_req", pm_req, h ? 0 : 1);
    chk("ret_valid", exec_valid, 0);
  endtask

  task automatic do_halt(input int idle);
    for (int i = 0; i < idle; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", pm_req, 0);
      chk("halt_pc", pc, mpc);
      exec_done     = 1'b1;
      branch_taken  = 1'b1;
      branch_target = PW'($urandom);
      @(negedge clk);
    end
    clear_ins();
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_req", pm_req, 1);
    chk("resume_addr", pm_addr, mpc);
  endtask

  task automatic do_timeout();
    for (int i = 0; i < TO; i++) begin
      chk("to_fault", fault, 0);
      chk("to_req", pm_req, 1);
      chk("to_addr", pm_addr, mpc);
      pm_ready = 1'b0;
      @(negedge clk);
    end
    chk("fault_set", fault, 1);
    chk("fault_pc", pc, mpc);
    chk("fault_req", pm_req, 0);
    for (int i = 0; i < 5; i++) begin
      pm_ready  = 1'b1;
      resume    = 1'b1;
      exec_done = 1'b1;
      @(negedge clk);
      chk("fault_sticky", fault, 1);
      chk("fault_pc_hold", pc, mpc);
    end
    clear_ins();
    pm_ready = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk_reset();
    release_reset();
  endtask

  initial begin
    bit h;
    bit br;
    reset         = 1'b1;
    pm_ready      = 1'b0;
    pm_data       = '0;
    branch_target = '0;
    clear_ins();
    mpc  = '0;
    mcnt = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    release_reset();

    do_fetch(0, 32'h70002040);
    do_exec(1, 1'b0, '0, 1'b0);
    chk("t1_pc", pc, 1);
    chk("t1_cnt", retired_count, 1);

    do_fetch(5, $urandom);
    do_exec(0, 1'b0, '0, 1'b0);
    do_fetch(TO - 1, $urandom);
    do_exec(2, 1'b0, '0, 1'b0);
    do_timeout();

    do_fetch(0, $urandom);
    do_exec(0, 1'b1, 10'h3F0, 1'b0);
    do_fetch(1, $urandom);
    do_exec(0, 1'b1, 10'h3FF, 1'b0);
    do_fetch(0, $urandom);
    do_exec(0, 1'b0, '0, 1'b0);
    chk("wrap_pc", pc, 0);

    do_fetch(0, $urandom);
    do_exec(0, 1'b1, 10'd4, 1'b0);
    do_fetch(0, $urandom);
    do_exec(0, 1'b0, '0, 1'b1);
    chk("halt_pc5", pc, 5);
    do_halt(10);
    do_fetch(0, $urandom);
    do_exec(0, 1'b1, 10'h123, 1'b1);
    do_halt(2);

    do_fetch(0, 32'h70002040);
    reset = 1'b1;
    @(negedge clk);
    chk_reset();
    release_reset();

    for (int i = 0; i < (1 << CW) + 2; i++) begin
      do_fetch(int'($urandom_range(0, 2)), $urandom);
      do_exec(int'($urandom_range(0, 2)), 1'b0, '0, 1'b0);
    end
    chk("cnt_wrap", retired_count, 2);

    for (int i = 0; i < 60; i++) begin
      br = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 7) == 0);
      do_fetch(int'($urandom_range(0, 6)), $urandom);
      do_exec(int'($urandom_range(0, 3)), br, PW'($urandom), h);
      if (h) do_halt(int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
